// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register outstanding-write scoreboard with RAW/WAW issue stall
//
// Purpose: tracks how many writes are in flight for each of x1..x31 and blocks
// issue of an instruction that reads a register with an unfinished write (RAW)
// or that would push a register's in-flight count past its maximum (WAW).
//
// Ports:
//   clk            - clock, all state updates on rising edge
//   reset          - asynchronous active-high reset, clears all state
//   issue_valid    - an instruction requests issue this cycle
//   issue_regWrite - issuing instruction writes issue_rd
//   issue_rd       - destination register of issuing instruction
//   issue_rs1/rs2  - source registers of issuing instruction
//   issue_use_rs1/rs2 - source actually read
//   wb_valid       - a register write completes this cycle
//   wb_rd          - register written back
//   stall          - combinational, issue blocked this cycle
//   issue_fire     - combinational, issue_valid & ~stall
//   pending        - registered, bit i set when register i has writes in flight
//   err            - registered sticky, writeback seen for a register with none in flight

module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_regWrite,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_use_rs1,
    input  logic        issue_use_rs2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic        stall,
    output logic        issue_fire,
    output logic [31:0] pending,
    output logic        err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [31:0]      pending_q, pending_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic             raw1, raw2, waw;
    logic             inc_en, wb_en, wb_paired;

    assign cnt_rs1 = cnt_q[issue_rs1];
    assign cnt_rs2 = cnt_q[issue_rs2];
    assign cnt_rd  = cnt_q[issue_rd];
    assign cnt_wb  = cnt_q[wb_rd];

    always_comb begin
        // A source whose only outstanding write is retiring this very cycle is
        // forwarded, so it does not block issue.
        raw1 = issue_use_rs1 && (issue_rs1 != 5'd0) && (cnt_rs1 != '0)
               && !(wb_valid && (wb_rd == issue_rs1) && (cnt_rs1 == CNT_ONE));
        raw2 = issue_use_rs2 && (issue_rs2 != 5'd0) && (cnt_rs2 != '0)
               && !(wb_valid && (wb_rd == issue_rs2) && (cnt_rs2 == CNT_ONE));
        // A saturated destination may still accept a write if one retires now.
        waw  = issue_regWrite && (issue_rd != 5'd0) && (cnt_rd == CNT_MAX)
               && !(wb_valid && (wb_rd == issue_rd));

        stall      = issue_valid && (raw1 || raw2 || waw);
        issue_fire = issue_valid && !stall;

        inc_en    = issue_fire && issue_regWrite && (issue_rd != 5'd0);
        wb_en     = wb_valid && (wb_rd != 5'd0);
        // Issue and writeback to the same register cancel out: the count is
        // left alone and the writeback is never treated as spurious.
        wb_paired = inc_en && wb_en && (wb_rd == issue_rd);
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (!wb_paired) begin
            if (inc_en) begin
                cnt_d[issue_rd] = cnt_rd + CNT_ONE;
            end
            if (wb_en && (cnt_wb != '0)) begin
                cnt_d[wb_rd] = cnt_wb - CNT_ONE;
            end
        end
        cnt_d[0] = '0;

        pending_d = '0;
        for (int i = 1; i < 32; i++) begin
            pending_d[i] = (cnt_d[i] != '0);
        end

        err_d = err_q || (wb_en && (cnt_wb == '0) && !wb_paired);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign pending = pending_q;
    assign err     = err_q;

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter: CNT_W, 2, width of per-register outstanding-write counter (saturation value 2^CNT_W-1 = 3).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have port: issue_valid  input  1  an instruction requests issue this cycle.
REQ-005 SHALL have port: issue_regWrite  input  1  issuing instruction writes a register.
REQ-006 SHALL have port: issue_rd  input  5  destination register of issuing instruction.
REQ-007 SHALL have port: issue_rs1 / issue_rs2  input  5 each  source registers of issuing instruction.
REQ-008 SHALL have port: issue_use_rs1 / issue_use_rs2  input  1 each  source actually read.
REQ-009 SHALL have port: wb_valid  input  1  a register write completes this cycle.
REQ-010 SHALL have port: wb_rd  input  5  register written back.
REQ-011 SHALL have port: stall  output  1  combinational; issue blocked this cycle.
REQ-012 SHALL have port: issue_fire  output  1  combinational; issue_valid & ~stall.
REQ-013 SHALL have port: pending  output  32  registered; bit i = counter[i] != 0.
REQ-014 SHALL have port: err  output  1  registered sticky; writeback to register with zero count.

Function
REQ-015 SHALL keep one CNT_W-bit counter per register x1..x31; x0 SHALL never be tracked (pending[0] constantly 0).
REQ-016 SHALL assert stall (RAW) when issue_valid and a used source rsN != 0 has counter[rsN] != 0, except the bypass in REQ-017.
REQ-017 SHALL not stall on rsN when wb_valid & wb_rd == rsN & counter[rsN] == 1 in the same cycle (writeback-to-issue bypass).
REQ-018 SHALL assert stall (WAW saturation) when issue_valid & issue_regWrite & issue_rd != 0 & counter[issue_rd] == max, unless a same-cycle wb to issue_rd exists.
REQ-019 SHALL increment counter[issue_rd] on the next edge when issue_fire & issue_regWrite & issue_rd != 0.
REQ-020 SHALL decrement counter[wb_rd] on the next edge when wb_valid & wb_rd != 0 & counter[wb_rd] != 0.
REQ-021 SHALL leave the counter unchanged when increment and decrement hit the same register in the same cycle.
REQ-022 SHALL ignore wb_valid with wb_rd == 0 (no counter change, no error).
REQ-023 SHALL set err on the next edge when wb_valid & wb_rd != 0 & counter[wb_rd] == 0 with no same-cycle increment to it; err holds until reset; counter stays 0 (no wrap).
REQ-024 SHALL never wrap a counter above max; REQ-018 guarantees no increment at max without a same-cycle decrement.
REQ-025 SHALL update pending one cycle after the counter change (registered alongside counters); stall SHALL use counters directly, zero added latency.
REQ-026 SHALL treat issue_valid = 0 as no issue: stall = 0, issue_fire = 0, no increment.

Reset
REQ-027 SHALL on reset assertion, asynchronously, clear all counters, pending = 32'h0, err = 0; stall and issue_fire then depend only on inputs.
REQ-028 SHALL discard any issue or writeback coincident with reset; first update occurs on the first edge after reset deasserts.

Verification
REQ-029 SHALL cover RAW: issue x5 write, next cycle issue reading rs1 = x5 -> stall = 1 until wb x5; wb x5 same cycle as issue -> stall = 0 (bypass), pending[5] = 0 next cycle.
REQ-030 SHALL cover WAW saturation: three issues to x7 without wb -> counter 3, fourth issue to x7 -> stall = 1; same with wb x7 in that cycle -> issue_fire = 1, count stays 3.
REQ-031 SHALL cover x0: issue rd = x0 and sources x0, wb x0 -> stall = 0, pending = 0, err = 0.
REQ-032 SHALL cover simultaneous issue and wb to x9 with count 1 -> count stays 1, pending[9] = 1.
REQ-033 SHALL cover spurious wb to x3 with count 0 -> err = 1 next cycle, holds; pending[3] = 0.
REQ-034 SHALL cover reset mid-operation: x4, x6 pending, err = 1, assert reset between edges -> pending = 0 and err = 0 immediately, before next clk edge.
